ddr_reset_initiator: RTL and testbench
======================================

// Module: ddr_reset_initiator
// PURPOSE
//  User-side initiator that drives the DDR reset sequencer's active-low reset input on demand and gates AXI traffic.
//  Quiesces AXI masters, pulses the DDR reset, then waits for the sequencer's done status before reopening traffic.
//  Sits between user control logic / AXI masters and the DDR reset sequencer, all on clk.
//  Adds a done-watchdog with bounded retry when compiled in.
// PARAMETERS
//  FREQ           100   clk frequency in MHz; sizes the watchdog timeout
//  RST_PULSE_CYC  16    cycles ddr_rstn_o is held low per reset attempt (>=2)
//  QUIESCE_TO_CYC 1024  max cycles to wait for axi_idle_i before forcing the reset
//  DONE_TO_MS     3     watchdog timeout in ms (DONE_TO_CYC = DONE_TO_MS*FREQ*1000)
//  MAX_RETRY      3     reset attempts after the first before declaring failure (1..15)
// PORTS
//  clk              in   1  clock, shared with the DDR reset sequencer
//  ddr_rstn_i       in   1  async active-low block reset
//  req_i            in   1  reset request, level-sampled in RUN only
//  axi_idle_i       in   1  1 = no outstanding AXI transactions
//  ddr_init_done_i  in   1  done status from the DDR reset sequencer
//  ddr_rstn_o       out  1  to the sequencer's active-low reset input
//  axi_hold_o       out  1  1 = masters must not issue new AXI requests
//  ready_o          out  1  1 = DDR usable (state RUN)
//  busy_o           out  1  1 = sequence in progress (QUIESCE/ASSERT/WAIT_DONE)
//  err_o            out  1  sticky failure flag (watchdog build only)
//  retry_cnt_o      out  4  attempts made in the current sequence (watchdog build only)
// BEHAVIOUR
//  Reset: ddr_rstn_i is asynchronous, active-low; clock is clk. Reset state = WAIT_DONE.
//   Reset values: ddr_rstn_o=1, axi_hold_o=1, ready_o=0, busy_o=1, err_o=0, retry_cnt_o=0.
//   Power-up DDR init is automatic, so no reset pulse is issued.
//  All outputs are registered and driven from the state; counters reload on every state entry.
//  WAIT_DONE: ddr_rstn_o=1, hold=1. ddr_init_done_i==1 sampled -> RUN the next cycle.
//  RUN: hold=0, ready=1, busy=0.
//   req_i==1 -> QUIESCE.
//   ddr_init_done_i==0 (external DDR reset) -> WAIT_DONE; hold=1 on the same edge as ready=0.
//   If req_i and done==0 occur together, the done==0 event wins.
//  QUIESCE: hold=1. axi_idle_i==1 or quiesce counter reaching QUIESCE_TO_CYC-1 -> ASSERT.
//   If axi_idle_i is already 1 on entry, leave after 1 cycle.
//  ASSERT: ddr_rstn_o=0 for exactly RST_PULSE_CYC cycles -> WAIT_DONE.
//  req_i is ignored outside RUN; no request is queued.
//  Counter widths: $clog2(max count + 1); no wrap-around, every counter saturates at its terminal value.
//  ddr_rstn_i low mid-sequence: immediate return to reset values.
//   ddr_rstn_o releases high asynchronously, with no partial pulse extension.
// CONFIGURATION
//  Macro DDR_RST_WATCHDOG_EN defined:
//   - WAIT_DONE counts cycles; on reaching DONE_TO_CYC with done still 0, retry_cnt_o is incremented.
//   - retry_cnt_o <= MAX_RETRY -> ASSERT; otherwise -> FAIL.
//   - FAIL: hold=1, ready=0, busy=0, err_o=1, ddr_rstn_o=1; exit only via ddr_rstn_i.
//   - retry_cnt_o clears on QUIESCE entry. The watchdog is also active in the post-reset WAIT_DONE.
//  Macro undefined: WAIT_DONE waits indefinitely, FAIL is absent, err_o and retry_cnt_o are tied to 0.
// TESTING (FREQ=1, RST_PULSE_CYC=16, QUIESCE_TO_CYC=1024, DONE_TO_MS=3, MAX_RETRY=3)
//  1. Release ddr_rstn_i; done=1 at cycle 10 -> ready_o=1 at cycle 11; ddr_rstn_o stays 1 throughout.
//  2. In RUN, req_i=1 for 1 cycle with axi_idle_i=1.
//     -> hold=1 on the next edge; ddr_rstn_o=0 for exactly 16 cycles.
//     -> With done returning 200 cycles later, ready_o=1 one cycle after.
//  3. In RUN, req_i=1 with axi_idle_i=0 held -> ddr_rstn_o falls after 1024 QUIESCE cycles (forced).
//  4. Mid-ASSERT, pulse ddr_rstn_i low.
//     -> ddr_rstn_o=1, hold=1, busy=1 immediately; the post-release path follows scenario 1.
//  5. In RUN, drop done with req_i=1 on the same cycle -> WAIT_DONE with no reset pulse issued.
//  6. [DDR_RST_WATCHDOG_EN] Hold done=0 after a request.
//     -> 4 pulses spaced 3000 cycles apart, retry_cnt_o=1,2,3.
//     -> err_o=1 after 4x3000 WAIT_DONE cycles; further req_i is ignored.

Source files
------------

// File: rtl/ddr_reset_initiator_if.sv
// Handshake/status bundle between user control logic and the DDR reset initiator.
// Ports: req_i, axi_idle_i, ddr_init_done_i (towards initiator); ddr_rstn_o, axi_hold_o,
//        ready_o, busy_o, err_o, retry_cnt_o (from initiator). slave = initiator side.
interface ddr_reset_initiator_if;
  logic       req_i;
  logic       axi_idle_i;
  logic       ddr_init_done_i;
  logic       ddr_rstn_o;
  logic       axi_hold_o;
  logic       ready_o;
  logic       busy_o;
  logic       err_o;
  logic [3:0] retry_cnt_o;

  modport master (
    output req_i, axi_idle_i, ddr_init_done_i,
    input  ddr_rstn_o, axi_hold_o, ready_o, busy_o, err_o, retry_cnt_o
  );

  modport slave (
    input  req_i, axi_idle_i, ddr_init_done_i,
    output ddr_rstn_o, axi_hold_o, ready_o, busy_o, err_o, retry_cnt_o
  );
endinterface

// File: rtl/ddr_reset_initiator.sv
// Purpose : on request, quiesce AXI masters, pulse the DDR sequencer's active-low reset,
//           then wait for its done status before reopening traffic.
// Latency : req_i -> axi_hold_o next edge; ddr_rstn_o low RST_PULSE_CYC cycles; done -> ready_o next edge.
// Backpressure: AXI held (axi_hold_o=1) from QUIESCE until done; req_i ignored outside RUN, never queued.
// Ports   : clk, ddr_rstn_i (async active-low), bus (ddr_reset_initiator_if.slave).
// Config  : define DDR_RST_WATCHDOG_EN for the done-watchdog with bounded retry and FAIL state;
//           without it err_o and retry_cnt_o are tied to 0 and WAIT_DONE waits indefinitely.
module ddr_reset_initiator #(
  parameter int FREQ           = 100,
  parameter int RST_PULSE_CYC  = 16,
  parameter int QUIESCE_TO_CYC = 1024,
  parameter int DONE_TO_MS     = 3,
  parameter int MAX_RETRY      = 3
) (
  input  logic                  clk,
  input  logic                  ddr_rstn_i,
  ddr_reset_initiator_if.slave  bus
);

  localparam int DONE_TO_CYC = DONE_TO_MS * FREQ * 1000;
  localparam int MAX_QP      = (QUIESCE_TO_CYC > RST_PULSE_CYC) ? QUIESCE_TO_CYC : RST_PULSE_CYC;
  localparam int CNT_MAX     = (DONE_TO_CYC > MAX_QP) ? DONE_TO_CYC : MAX_QP;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] QUI_LAST   = CNT_W'(QUIESCE_TO_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE_CYC - 1);

`ifdef DDR_RST_WATCHDOG_EN
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TO_CYC - 1);
  localparam logic [4:0]       RETRY_MAX = 5'(MAX_RETRY);

  typedef enum logic [2:0] {S_RUN, S_QUIESCE, S_ASSERT, S_WAIT_DONE, S_FAIL} state_t;
`else
  typedef enum logic [1:0] {S_RUN, S_QUIESCE, S_ASSERT, S_WAIT_DONE} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             rstn_q, hold_q, ready_q, busy_q;

  // Shared state counter; reloaded on every state entry, never wraps.
  assign cnt_inc = (cnt == CNT_TOP) ? cnt : cnt + 1'b1;

`ifdef DDR_RST_WATCHDOG_EN
  logic       err_q;
  logic [3:0] retry_q;
  logic [4:0] retry_nxt;

  // One bit wider so the retry limit compare cannot alias at MAX_RETRY=15.
  assign retry_nxt = {1'b0, retry_q} + 5'd1;
`endif

  always_ff @(posedge clk or negedge ddr_rstn_i) begin
    if (!ddr_rstn_i) begin
      // Power-up DDR init runs on its own: start in WAIT_DONE without pulsing.
      state   <= S_WAIT_DONE;
      cnt     <= '0;
      rstn_q  <= 1'b1;
      hold_q  <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
`ifdef DDR_RST_WATCHDOG_EN
      err_q   <= 1'b0;
      retry_q <= '0;
`endif
    end else begin
      case (state)
        S_RUN: begin
          // External DDR reset takes priority over a user request.
          if (!bus.ddr_init_done_i) begin
            state   <= S_WAIT_DONE;
            cnt     <= '0;
            hold_q  <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else if (bus.req_i) begin
            state   <= S_QUIESCE;
            cnt     <= '0;
            hold_q  <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef DDR_RST_WATCHDOG_EN
            retry_q <= '0;
`endif
          end
        end
        S_QUIESCE: begin
          // Reset is forced after the quiesce timeout even if masters never go idle.
          if (bus.axi_idle_i || cnt == QUI_LAST) begin
            state  <= S_ASSERT;
            cnt    <= '0;
            rstn_q <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_ASSERT: begin
          if (cnt == PULSE_LAST) begin
            state  <= S_WAIT_DONE;
            cnt    <= '0;
            rstn_q <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_WAIT_DONE: begin
          if (bus.ddr_init_done_i) begin
            state   <= S_RUN;
            cnt     <= '0;
            hold_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
`ifdef DDR_RST_WATCHDOG_EN
          else if (cnt == DONE_LAST) begin
            cnt     <= '0;
            retry_q <= retry_nxt[4] ? 4'hF : retry_nxt[3:0];
            if (retry_nxt > RETRY_MAX) begin
              state  <= S_FAIL;
              busy_q <= 1'b0;
              err_q  <= 1'b1;
            end else begin
              state  <= S_ASSERT;
              rstn_q <= 1'b0;
            end
          end else begin
            cnt <= cnt_inc;
          end
`endif
        end
`ifdef DDR_RST_WATCHDOG_EN
        S_FAIL: begin
          // Terminal: only ddr_rstn_i leaves this state.
          state <= S_FAIL;
        end
`endif
        default: begin
          state  <= S_WAIT_DONE;
          cnt    <= '0;
          rstn_q <= 1'b1;
          hold_q <= 1'b1;
          ready_q <= 1'b0;
          busy_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ddr_rstn_o = rstn_q;
  assign bus.axi_hold_o = hold_q;
  assign bus.ready_o    = ready_q;
  assign bus.busy_o     = busy_q;

`ifdef DDR_RST_WATCHDOG_EN
  assign bus.err_o       = err_q;
  assign bus.retry_cnt_o = retry_q;
`else
  assign bus.err_o       = 1'b0;
  assign bus.retry_cnt_o = 4'd0;
`endif

endmodule

// File: tb/tb_ddr_reset_initiator.sv
// Bench for ddr_reset_initiator: directed scenarios push expected output-change events
// (edge index + output vector) into a queue; a monitor pops one per observed change.
// Output vector = {ddr_rstn_o, axi_hold_o, ready_o, busy_o, err_o, retry_cnt_o[3:0]}.
module tb_ddr_reset_initiator;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    int         cyc;
    logic [8:0] val;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [8:0] V_RST  = 9'b1_1_0_1_0_0000;
  localparam logic [8:0] V_WAIT = 9'b1_1_0_1_0_0000;
  localparam logic [8:0] V_QUI  = 9'b1_1_0_1_0_0000;
  localparam logic [8:0] V_ASR  = 9'b0_1_0_1_0_0000;
  localparam logic [8:0] V_RUN  = 9'b1_0_1_0_0_0000;

  ddr_reset_initiator_if ifc ();

  ddr_reset_initiator #(
    .FREQ           (1),
    .RST_PULSE_CYC  (16),
    .QUIESCE_TO_CYC (1024),
    .DONE_TO_MS     (3),
    .MAX_RETRY      (3)
  ) dut (
    .clk        (clk),
    .ddr_rstn_i (rst_n),
    .bus        (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] out_vec();
    return {ifc.ddr_rstn_o, ifc.axi_hold_o, ifc.ready_o, ifc.busy_o, ifc.err_o, ifc.retry_cnt_o};
  endfunction

  function automatic void push(input int c, input logic [8:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endfunction

  // Monitor: samples 2 time units after each rising edge, labels a change with that edge index.
  initial begin
    logic [8:0] prev;
    logic [8:0] cur;
    exp_t       e;
    prev = 'x;
    forever begin
      @(posedge clk);
      #2;
      cur = out_vec();
      if (cur !== prev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event edge=%0d got=%b required=no change", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.val !== cur) begin
            n_err++;
            $display("FAIL event edge=%0d got=%b required edge=%0d val=%b", cyc, cur, e.cyc, e.val);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    int c;
    ifc.req_i           = 1'b0;
    ifc.axi_idle_i      = 1'b1;
    ifc.ddr_init_done_i = 1'b0;

    // 1: power-up, no reset pulse, ready one edge after done.
    push(1, V_RST);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    ifc.ddr_init_done_i = 1'b1;
    push(cyc + 1, V_RUN);

    // 2: request with idle masters -> 1-cycle quiesce, 16-cycle pulse, done 200 cycles later.
    repeat (5) @(negedge clk);
    c = cyc;
    ifc.req_i = 1'b1;
    push(c + 1, V_QUI);
    push(c + 2, V_ASR);
    push(c + 18, V_WAIT);
    @(negedge clk);
    ifc.req_i           = 1'b0;
    ifc.ddr_init_done_i = 1'b0;
    while (cyc < c + 50) @(negedge clk);
    ifc.req_i = 1'b1;   // ignored in WAIT_DONE, must not be queued
    @(negedge clk);
    ifc.req_i = 1'b0;
    while (cyc < c + 218) @(negedge clk);
    ifc.ddr_init_done_i = 1'b1;
    push(c + 219, V_RUN);

    // 3: masters never idle -> reset forced after 1024 quiesce cycles.
    repeat (5) @(negedge clk);
    c = cyc;
    ifc.axi_idle_i = 1'b0;
    ifc.req_i      = 1'b1;
    push(c + 1, V_QUI);
    push(c + 1025, V_ASR);
    push(c + 1041, V_WAIT);
    @(negedge clk);
    ifc.req_i           = 1'b0;
    ifc.ddr_init_done_i = 1'b0;
    while (cyc < c + 1041) @(negedge clk);
    ifc.axi_idle_i = 1'b1;
    repeat (10) @(negedge clk);
    ifc.ddr_init_done_i = 1'b1;
    push(cyc + 1, V_RUN);

    // 4: block reset mid-pulse -> reset values at once, pulse not extended.
    repeat (5) @(negedge clk);
    c = cyc;
    ifc.req_i = 1'b1;
    push(c + 1, V_QUI);
    push(c + 2, V_ASR);
    @(negedge clk);
    ifc.req_i           = 1'b0;
    ifc.ddr_init_done_i = 1'b0;
    while (cyc < c + 8) @(negedge clk);
    rst_n = 1'b0;
    push(c + 9, V_RST);
    #1;
    n_cmp++;
    if (out_vec() !== V_RST) begin
      n_err++;
      $display("FAIL async_reset got=%b required=%b", out_vec(), V_RST);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    ifc.ddr_init_done_i = 1'b1;
    push(cyc + 1, V_RUN);

    // 5: done drops together with req -> WAIT_DONE, no pulse.
    repeat (5) @(negedge clk);
    c = cyc;
    ifc.ddr_init_done_i = 1'b0;
    ifc.req_i           = 1'b1;
    push(c + 1, V_WAIT);
    @(negedge clk);
    ifc.req_i = 1'b0;
    repeat (40) @(negedge clk);
    ifc.ddr_init_done_i = 1'b1;
    push(cyc + 1, V_RUN);

`ifdef DDR_RST_WATCHDOG_EN
    // 6: done never returns -> 3 retries 3000 WAIT_DONE cycles apart, then FAIL.
    repeat (5) @(negedge clk);
    c = cyc;
    ifc.req_i = 1'b1;
    push(c + 1, V_QUI);
    push(c + 2, V_ASR);
    push(c + 18, V_WAIT);
    for (int k = 1; k <= 3; k++) begin
      logic [3:0] r;
      r = 4'(k);
      push(c + 18 + 3016 * (k - 1) + 3000, {4'b0101, 1'b0, r});
      push(c + 18 + 3016 * (k - 1) + 3016, {4'b1101, 1'b0, r});
    end
    push(c + 18 + 3016 * 3 + 3000, 9'b1_1_0_0_1_0100);
    @(negedge clk);
    ifc.req_i           = 1'b0;
    ifc.ddr_init_done_i = 1'b0;
    while (cyc < c + 18 + 3016 * 3 + 3010) @(negedge clk);
    ifc.req_i = 1'b1;   // FAIL is only left through ddr_rstn_i
    repeat (3) @(negedge clk);
    ifc.req_i           = 1'b0;
    ifc.ddr_init_done_i = 1'b1;
    repeat (20) @(negedge clk);
`endif

    repeat (20) @(negedge clk);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_event got=none required edge=%0d val=%b", e.cyc, e.val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
